// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FINISH
  } state_e;

  function automatic int cnt_width(input int dw);
    return $clog2(dw) + 1;
  endfunction

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_W          = cnt_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (W'(0) - i_val) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider sharing one
// 2*W product/remainder register, fixed latency regardless of op.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(W);

  state_e          r_state;
  op_e             r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_aneg, r_bneg, r_special, r_busy, r_done, r_zero;
  logic [W-1:0]    r_opnd, r_spec, r_result;
  logic [2*W-1:0]  r_prod;

  op_e             w_op;
  logic            w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [W-1:0]    w_mag_a, w_mag_b, w_spec_val, w_dfix, w_res;
  logic [W:0]      w_msum, w_dshift, w_ddiff;
  logic [2*W-1:0]  w_mul_step, w_div_step, w_pfix;

  assign w_op    = op_e'(op);
  assign w_a_neg = SrcA[W-1] & ((w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                                (w_op == OP_DIV)  || (w_op == OP_REM));
  assign w_b_neg = SrcB[W-1] & ((w_op == OP_MULH) || (w_op == OP_DIV) ||
                                (w_op == OP_REM));

  muldiv_negate #(.W(W)) u_mag_a (.i_val(SrcA), .i_neg(w_a_neg), .o_val(w_mag_a));
  muldiv_negate #(.W(W)) u_mag_b (.i_val(SrcB), .i_neg(w_b_neg), .o_val(w_mag_b));

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign w_div0 = op[2] && (SrcB == '0);
  assign w_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                  (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);

  always_comb begin
    w_spec_val = '0;
    if (w_div0)     w_spec_val = op[1] ? SrcA : '1;
    else if (w_ovf) w_spec_val = op[1] ? '0   : SrcA;
  end

  // Multiply: conditional add into the high half, then shift right.
  assign w_msum     = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
  assign w_mul_step = {w_msum, r_prod[W-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  assign w_dshift   = {r_prod[2*W-1:W], r_prod[W-1]};
  assign w_ddiff    = w_dshift - {1'b0, r_opnd};
  assign w_div_step = w_ddiff[W] ? {w_dshift[W-1:0], r_prod[W-2:0], 1'b0}
                                 : {w_ddiff[W-1:0],  r_prod[W-2:0], 1'b1};

  muldiv_negate #(.W(2*W)) u_fix_p (
    .i_val(r_prod), .i_neg(r_aneg ^ r_bneg), .o_val(w_pfix));
  muldiv_negate #(.W(W)) u_fix_d (
    .i_val(r_op[1] ? r_prod[2*W-1:W] : r_prod[W-1:0]),
    .i_neg(r_op[1] ? r_aneg : (r_aneg ^ r_bneg)),
    .o_val(w_dfix));

  assign w_res = r_special ? r_spec :
                 r_op[2]   ? w_dfix :
                 (r_op == OP_MUL) ? w_pfix[W-1:0] : w_pfix[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MUL;
      r_cnt     <= '0;
      r_aneg    <= 1'b0;
      r_bneg    <= 1'b0;
      r_special <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_zero    <= 1'b1;
      r_opnd    <= '0;
      r_spec    <= '0;
      r_result  <= '0;
      r_prod    <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_op      <= w_op;
            r_aneg    <= w_a_neg;
            r_bneg    <= w_b_neg;
            r_opnd    <= op[2] ? w_mag_b : w_mag_a;
            r_prod    <= {{W{1'b0}}, (op[2] ? w_mag_a : w_mag_b)};
            r_cnt     <= '0;
            r_special <= w_div0 | w_ovf;
            r_spec    <= w_spec_val;
            r_busy    <= 1'b1;
            r_state   <= (w_div0 | w_ovf) ? S_FINISH : S_BUSY;
          end
          S_BUSY: begin
            r_prod <= r_op[2] ? w_div_step : w_mul_step;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CW'(W-1)) r_state <= S_FINISH;
          end
          S_FINISH: begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign Result = r_result;
  assign Zero   = r_zero;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit executing the RV32M operations beside the single-cycle ALU in the execute stage. It takes two DATA_WIDTH operands and a 3-bit op code and produces the result after a fixed, op-independent latency using a shift-add multiplier and a restoring divider. A start/busy/done handshake lets the pipeline stall on it, and a flush input aborts work in flight.

## Interface
- DATA_WIDTH, 32: operand/result width; must be even and ≥ 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; accepted only when busy = 0 and flush = 0.
- op  input  3  operation, RV funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  DATA_WIDTH  rs1 operand: multiplicand or dividend.
- SrcB  input  DATA_WIDTH  rs2 operand: multiplier or divisor.
- flush  input  1  synchronous abort.
- busy  output  1  high from the cycle after acceptance through the FINISH cycle.
- done  output  1  one-cycle pulse when Result is updated.
- Result  output  DATA_WIDTH  registered result, held until the next done.
- Zero  output  1  registered; equals (Result == 0).

## Operation
- FSM states and transitions:
  - IDLE → BUSY on acceptance (normal operands).
  - IDLE → FINISH on acceptance for a special case.
  - BUSY → FINISH after DATA_WIDTH iterations.
  - FINISH → IDLE.
- On acceptance, register op, sign flags, and the operand magnitudes. Signedness per op:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: SrcA signed, SrcB unsigned.
  - Other ops: both operands unsigned.
- Multiply: 2·DATA_WIDTH-bit product register, one shift-add per BUSY cycle, using magnitudes.
  - In FINISH, negate the product if exactly one signed operand is negative.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide: restoring division on magnitudes, one quotient bit per BUSY cycle.
  - In FINISH, negate the quotient if the operand signs differ (signed ops only).
  - The remainder takes the sign of the dividend.
- Special cases are resolved at acceptance, skip BUSY, and go straight to FINISH:
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give SrcA.
  - Signed overflow (SrcA = most-negative value, SrcB = −1): DIV gives SrcA; REM gives 0.
- start while busy = 1 is ignored. Requests are not queued, so the requester must hold start until it is accepted.
- flush in any state returns to IDLE next cycle. No done is produced, and Result and Zero are unchanged.
- flush together with start in IDLE: flush wins and the request is dropped.
- Reset values: state IDLE, busy 0, done 0, Result 0, Zero 1, all internal registers 0. Reset mid-operation discards the work and produces no done.

## Timing
- Acceptance edge = cycle 0.
- Normal ops: BUSY cycles 1..DATA_WIDTH, FINISH in cycle DATA_WIDTH+1. done is high and Result valid in cycle DATA_WIDTH+2, i.e. 34 cycles after acceptance at DATA_WIDTH = 32.
- Special cases: FINISH in cycle 1, done and Result in cycle 2.
- busy is 0 in the cycle done is high, so a new start in that cycle is accepted (back-to-back issue).
- Zero updates in the same cycle as Result.
- No combinational path from any input to any output.

## Structure
- Package muldiv_pkg holds:
  - the op enum (funct3 values),
  - the FSM state enum {IDLE, BUSY, FINISH},
  - the localparam for the iteration-counter width, $clog2(DATA_WIDTH)+1.
- One sub-module is natural: muldiv_negate, a parametrised conditional two's-complement negator. It is instantiated for the operand magnitudes and for the FINISH sign fix.
- The FSM, counter and datapath stay in muldiv_unit.

## Test plan
- MUL: 7 × −3 → Result 0xFFFFFFEB, done at cycle 34, busy low the same cycle. MULHU: 0xFFFFFFFF × 0xFFFFFFFF → Result 0xFFFFFFFE.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHSU: 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV: −7 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU: 100 / 7 → 14; REMU → 2, Zero 0.
- Divisor 0: DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with done at cycle 2. DIV 0x80000000 / −1 → 0x80000000; REM of the same operands → 0 with Zero = 1.
- Assert start every cycle during a DIV: no extra acceptance while busy. A start in the done cycle is accepted and its result arrives exactly 34 cycles later.
- flush at cycle 10 of a MUL → IDLE, no done, Result unchanged. Repeat the same scenario with rst_n pulsed low instead of flush → all outputs take their reset values and no done follows.
